smj_stream_judge: RTL and testbench
===================================

# smj_stream_judge

Sequential, parametrised successor to the combinational five-tile SMJ judge. Accepts a hand of 3·MELDS+2 tiles one per cycle over a valid/ready handshake and builds a 34-bin tile histogram. It then tests every pair candidate for a complete standard decomposition (MELDS melds + one pair), and returns a 2-bit verdict after a fixed latency. It sits between the tile-stream front end and the scoring logic, and is driven by the same PATTERN-style bench as SMJ.

## Interface
- MELDS, default 4: melds per hand. Localparam HAND_SIZE = 3·MELDS+2 (default 14). Legal range is 1..4.
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_tile is valid this cycle.
- in_tile  input  6  tile code. [5:4] is the suit: 0 man, 1 pin, 2 sou, 3 honor. [3:0] is the rank: 1–9 for numbered suits, 1–7 for honors.
- in_ready  output  1  block accepts a tile this cycle.
- out_valid  output  1  one-cycle pulse; out_data is valid.
- out_data  output  2  verdict: 00 no win, 01 standard win, 10 invalid hand, 11 seven pairs (see Configuration).

## Operation
- Tile index = suit·9 + rank−1, giving 0..33. Honors occupy 27..33.
- A tile code is illegal if rank is 0, a numbered rank is >9, or an honor rank is >7. An illegal code sets a sticky bad flag and is not binned.
- Histogram is 34 × 3-bit counters that saturate at 7. Any final count >4 also marks the hand invalid.
- FSM states and transitions:
  - IDLE → LOAD on the first accepted tile.
  - LOAD → VALIDATE after HAND_SIZE tiles are accepted.
  - VALIDATE → CHECK after 1 cycle.
  - CHECK → DONE after 34 cycles.
  - DONE → IDLE after 1 cycle.
- in_ready = 1 in IDLE and LOAD only. A transfer occurs when in_valid && in_ready. in_valid while in_ready=0 is ignored.
- VALIDATE: evaluates bad flag / count >4. Under SMJ_SEVEN_PAIRS_EN it also evaluates the seven-pairs test.
- CHECK: one candidate p per cycle, p = 0..33. Candidates with count[p] < 2 are skipped.
- Per-candidate check: copy the histogram and subtract 2 at p. Then scan i = 0..33 in order:
  - if c[i] ≥ 3, subtract 3;
  - if c[i] > 0 remains, i must be a numbered tile with rank ≤7, and c[i+1] and c[i+2] must each be ≥ c[i]; subtract c[i] from i, i+1, i+2.
  - Any violation fails the candidate. A candidate passes when all residues are zero.
- Any passing candidate sets the win flag. There is no early exit.
- Verdict priority: invalid (10) > standard win (01) > seven pairs (11) > no win (00).
- DONE clears the histogram, tile counter and flags.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=00, state IDLE, histogram zero.
- The last tile is accepted at edge T. out_valid=1 in the cycle after edge T+36, so latency is a fixed 36 cycles regardless of verdict.
- in_ready deasserts the cycle after the last tile and reasserts in the same cycle as out_valid. A new hand's first tile may be accepted in the out_valid cycle.
- out_data holds its value until the next out_valid; it is not cleared.
- No output backpressure; out_valid is a single-cycle pulse.
- Gaps in in_valid during LOAD are allowed; the tile counter simply waits.
- rst asserted at any point, including mid-LOAD or mid-CHECK, aborts the hand immediately with no out_valid.

## Configuration
- SMJ_SEVEN_PAIRS_EN defined: when MELDS==4, a hand of exactly seven distinct bins each with count 2 yields 11, unless a standard win applies. Four-of-a-kind never counts as two pairs.
- Macro undefined: seven-pairs logic is absent, and 11 is never produced; such hands return 00.

## Structure
- Package smj_pkg holds:
  - tile_t (6-bit packed) and suit enum;
  - NUM_KINDS=34 and result codes RES_NONE/RES_WIN/RES_BAD/RES_7P;
  - function tile_idx() and function tile_legal().
- Sub-module smj_meld_check: combinational. Takes the histogram and candidate p; outputs pass. It is instantiated once and time-multiplexed over the 34 CHECK cycles.

## Test plan
- 1m1m1m 2m3m4m 5p6p7p 7s8s9s EE (0x01×3,0x02,0x03,0x04,0x15,0x16,0x17,0x27,0x28,0x29,0x31,0x31) → out_data 01 exactly 36 cycles after the last tile.
- 1m1m1m2m3m4m5m6m7m8m9m9m9m+5m (nine-gates shape) → 01. Same hand with 5m replaced by the East honor 0x31 → 00.
- Seven pairs 1m 9m 1p 9p 1s E S (each ×2) → 11 with SMJ_SEVEN_PAIRS_EN, 00 without. Five copies of 0x01 in the hand → 10.
- Illegal code 0x0A (man rank 10) or 0x38 (honor rank 8) anywhere in the hand → 10 with the same 36-cycle latency.
- rst pulsed after the 7th tile, then a full valid hand sent → only one out_valid, carrying that hand's verdict. in_valid held high during CHECK → in_ready=0 and no tiles absorbed.
- MELDS=1 (5 tiles): 2p3p4p+NN → 01. Back-to-back hands with the next first tile presented in the out_valid cycle → accepted.

Source files
------------

// File: rtl/smj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smj_pkg
// Purpose  : Shared types, constants and tile helpers for smj_stream_judge.
// Revision : 1.0 - initial release
// ============================================================================
package smj_pkg;

  localparam int NUM_KINDS  = 34;
  localparam int HONOR_BASE = 27;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_BAD  = 2'b10;
  localparam logic [1:0] RES_7P   = 2'b11;

  typedef enum logic [1:0] {
    SUIT_MAN   = 2'd0,
    SUIT_PIN   = 2'd1,
    SUIT_SOU   = 2'd2,
    SUIT_HONOR = 2'd3
  } suit_t;

  typedef struct packed {
    suit_t      suit;
    logic [3:0] rank;
  } tile_t;

  // One saturating 3-bit counter per tile kind
  typedef logic [NUM_KINDS-1:0][2:0] hist_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_VALIDATE = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Histogram bin: suit*9 + rank-1 (honors land on 27..33)
  function automatic logic [5:0] tile_idx(input tile_t t);
    return (6'(t.suit) * 6'd9) + {2'b00, t.rank} - 6'd1;
  endfunction

  // Rank 0 is never legal; numbered suits stop at 9, honors at 7
  function automatic logic tile_legal(input tile_t t);
    if (t.rank == 4'd0) return 1'b0;
    if (t.suit == SUIT_HONOR) return (t.rank <= 4'd7);
    return (t.rank <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/smj_stream_judge_if.sv
`default_nettype none
// ============================================================================
// Module   : smj_stream_judge_if
// Purpose  : Tile stream in (valid/ready) and verdict pulse out.
// Revision : 1.0 - initial release
// ============================================================================
interface smj_stream_judge_if;
  import smj_pkg::*;

  logic       in_valid;
  tile_t      in_tile;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;

  modport master (
    output in_valid, in_tile,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_tile,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/smj_meld_check.sv
`default_nettype none
// ============================================================================
// Module   : smj_meld_check
// Purpose  : Combinational test of one pair candidate: remove the pair, then
//            peel triplets/runs from the lowest bin upward; pass when the
//            histogram empties exactly.
// Revision : 1.0 - initial release
// ============================================================================
module smj_meld_check
  import smj_pkg::*;
(
  input  hist_t      hist,
  input  logic [5:0] cand,
  output logic       pass
);

  function automatic logic residue_clear(input hist_t h, input logic [5:0] p);
    logic [2:0] c [NUM_KINDS+2];
    logic       ok;
    for (int i = 0; i < NUM_KINDS; i++) c[i] = h[i];
    // two zero guard bins so a run probe past 33 reads empty
    c[NUM_KINDS]   = 3'd0;
    c[NUM_KINDS+1] = 3'd0;
    ok   = (h[p] >= 3'd2);
    c[p] = c[p] - 3'd2;
    for (int i = 0; i < NUM_KINDS; i++) begin
      if (c[i] >= 3'd3) c[i] = c[i] - 3'd3;
      if (c[i] != 3'd0) begin
        // leftovers must start runs: numbered tile, rank 1..7
        if ((i >= HONOR_BASE) || ((i % 9) > 6) || (c[i+1] < c[i]) || (c[i+2] < c[i])) begin
          ok = 1'b0;
        end else begin
          c[i+1] = c[i+1] - c[i];
          c[i+2] = c[i+2] - c[i];
          c[i]   = 3'd0;
        end
      end
    end
    return ok;
  endfunction

  // Evaluate the currently selected candidate
  always_comb begin
    pass = residue_clear(hist, cand);
  end

endmodule
`default_nettype wire

// File: rtl/smj_stream_judge.sv
`default_nettype none
// ============================================================================
// Module   : smj_stream_judge
// Purpose  : Streams a 3*MELDS+2 tile hand into a histogram, validates it,
//            sweeps all 34 pair candidates through one meld checker and
//            emits a 2-bit verdict a fixed 36 cycles after the last tile.
//            Optional macro SMJ_SEVEN_PAIRS_EN adds the seven-pairs verdict.
// Revision : 1.0 - initial release
// ============================================================================
module smj_stream_judge
  import smj_pkg::*;
#(
  parameter int MELDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  smj_stream_judge_if.slave bus
);

  localparam int               HAND_SIZE = 3 * MELDS + 2;
  localparam int               CNT_W     = $clog2(HAND_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(HAND_SIZE - 1);
  localparam logic [5:0]       LAST_CAND = 6'(NUM_KINDS - 1);

  state_t           state;
  hist_t            hist;
  logic [CNT_W-1:0] tile_cnt;
  logic [5:0]       cand;
  logic             bad_flag;
  logic             win_flag;
  logic             sp_flag;
  logic             done_pulse;
  logic [1:0]       verdict;

  logic             accept;
  logic             tile_ok;
  logic [5:0]       idx;
  logic             over;
  logic             seven;
  logic             cand_pass;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign bus.out_valid = done_pulse;
  assign bus.out_data  = verdict;

  assign accept  = bus.in_valid && bus.in_ready;
  assign tile_ok = tile_legal(bus.in_tile);
  assign idx     = tile_idx(bus.in_tile);

  // Any bin above four copies makes the hand physically impossible
  always_comb begin
    over = 1'b0;
    for (int i = 0; i < NUM_KINDS; i++) begin
      if (hist[i] > 3'd4) over = 1'b1;
    end
  end

`ifdef SMJ_SEVEN_PAIRS_EN
  logic [5:0] pair_cnt;

  // Seven bins of exactly two; a quad never counts as two pairs
  always_comb begin
    pair_cnt = 6'd0;
    for (int i = 0; i < NUM_KINDS; i++) begin
      if (hist[i] == 3'd2) pair_cnt = pair_cnt + 6'd1;
    end
    seven = (MELDS == 4) && (pair_cnt == 6'd7);
  end
`else
  assign seven = 1'b0;
`endif

  smj_meld_check u_meld_check (
    .hist (hist),
    .cand (cand),
    .pass (cand_pass)
  );

  // Hand sequencer: load, validate, 34-cycle candidate sweep, verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hist       <= '0;
      tile_cnt   <= '0;
      cand       <= 6'd0;
      bad_flag   <= 1'b0;
      win_flag   <= 1'b0;
      sp_flag    <= 1'b0;
      done_pulse <= 1'b0;
      verdict    <= RES_NONE;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (tile_ok) begin
              if (hist[idx] != 3'd7) hist[idx] <= hist[idx] + 3'd1;
            end else begin
              bad_flag <= 1'b1;
            end
            tile_cnt <= tile_cnt + CNT_W'(1);
            state    <= (tile_cnt == LAST_TILE) ? ST_VALIDATE : ST_LOAD;
          end
        end
        ST_VALIDATE: begin
          if (over) bad_flag <= 1'b1;
          sp_flag <= seven;
          cand    <= 6'd0;
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (cand_pass) win_flag <= 1'b1;
          if (cand == LAST_CAND) state <= ST_DONE;
          else                   cand  <= cand + 6'd1;
        end
        ST_DONE: begin
          done_pulse <= 1'b1;
          verdict    <= bad_flag ? RES_BAD :
                        win_flag ? RES_WIN :
                        sp_flag  ? RES_7P  : RES_NONE;
          hist       <= '0;
          tile_cnt   <= '0;
          bad_flag   <= 1'b0;
          win_flag   <= 1'b0;
          sp_flag    <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smj_stream_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_smj_stream_judge
// Purpose  : Scoreboard bench for smj_stream_judge (MELDS=4 and MELDS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_smj_stream_judge;

  typedef logic [5:0] tq_t [$];
  typedef struct {
    int v;
    int t;
  } exp_t;

`ifdef SMJ_SEVEN_PAIRS_EN
  localparam int EXP_7P = 3;
`else
  localparam int EXP_7P = 0;
`endif

  logic       clk;
  logic       rst;
  logic       drv_valid;
  logic [5:0] drv_tile;
  bit         sel;
  logic       cur_ready;
  int         cyc = 0;
  int         total = 0;
  int         nbad = 0;
  int         first_acc;
  int         last_acc;
  int         prev_last;
  exp_t       exp4 [$];
  exp_t       exp1 [$];
  exp_t       e4;
  exp_t       e1;

  smj_stream_judge_if bus4 ();
  smj_stream_judge_if bus1 ();

  assign bus4.in_valid = drv_valid && !sel;
  assign bus1.in_valid = drv_valid && sel;
  assign bus4.in_tile  = drv_tile;
  assign bus1.in_tile  = drv_tile;
  assign cur_ready     = sel ? bus1.in_ready : bus4.in_ready;

  smj_stream_judge #(.MELDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  smj_stream_judge #(.MELDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [5:0] code_of(input int idx);
    logic [1:0] s;
    logic [3:0] r;
    s = 2'(idx / 9);
    r = 4'(idx % 9 + 1);
    return {s, r};
  endfunction

  // Reference: hand = pair + any subset of triplets + runs; try every subset
  function automatic int model(input tq_t h, input int melds);
    int cnt [36];
    int w [36];
    int trips [$];
    int npairs, s, r;
    bit bad_hand, win, ok;
    bad_hand = 0; win = 0; npairs = 0;
    for (int i = 0; i < 36; i++) cnt[i] = 0;
    foreach (h[k]) begin
      s = int'(h[k][5:4]);
      r = int'(h[k][3:0]);
      if (r == 0 || r > ((s == 3) ? 7 : 9)) bad_hand = 1;
      else cnt[s * 9 + r - 1]++;
    end
    for (int i = 0; i < 34; i++) begin
      if (cnt[i] > 4) bad_hand = 1;
      if (cnt[i] == 2) npairs++;
    end
    for (int p = 0; p < 34; p++) begin
      if (cnt[p] >= 2) begin
        trips.delete();
        for (int i = 0; i < 34; i++)
          if (cnt[i] - ((i == p) ? 2 : 0) >= 3) trips.push_back(i);
        for (int m = 0; m < (1 << trips.size()); m++) begin
          w = cnt;
          w[p] -= 2;
          foreach (trips[b]) if (((m >> b) & 1) == 1) w[trips[b]] -= 3;
          ok = 1;
          for (int i = 0; i < 34; i++) begin
            if (w[i] != 0) begin
              if (i >= 27 || (i % 9) > 6 || w[i+1] < w[i] || w[i+2] < w[i]) ok = 0;
              else begin
                w[i+1] -= w[i];
                w[i+2] -= w[i];
                w[i] = 0;
              end
            end
          end
          if (ok) win = 1;
        end
      end
    end
    if (bad_hand) return 2;
    if (win) return 1;
`ifdef SMJ_SEVEN_PAIRS_EN
    if (melds == 4 && npairs == 7) return 3;
`endif
    return 0;
  endfunction

  function automatic tq_t unpack_hand(input logic [83:0] v, input int n);
    tq_t q;
    for (int k = 0; k < n; k++) q.push_back(v[(n - 1 - k) * 6 +: 6]);
    return q;
  endfunction

  function automatic tq_t dir_hand(input int d);
    logic [83:0] v;
    case (d)
      0: v = {6'h01,6'h01,6'h01,6'h02,6'h03,6'h04,6'h15,6'h16,6'h17,6'h27,6'h28,6'h29,6'h31,6'h31};
      1: v = {6'h01,6'h01,6'h01,6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08,6'h09,6'h09,6'h09,6'h05};
      2: v = {6'h01,6'h01,6'h01,6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08,6'h09,6'h09,6'h09,6'h31};
      3: v = {6'h01,6'h01,6'h09,6'h09,6'h11,6'h11,6'h19,6'h19,6'h21,6'h21,6'h31,6'h31,6'h32,6'h32};
      4: v = {6'h01,6'h01,6'h01,6'h01,6'h01,6'h02,6'h03,6'h04,6'h15,6'h16,6'h17,6'h27,6'h28,6'h29};
      5: v = {6'h01,6'h01,6'h01,6'h02,6'h03,6'h0A,6'h15,6'h16,6'h17,6'h27,6'h28,6'h29,6'h31,6'h31};
      default: v = {6'h01,6'h01,6'h01,6'h02,6'h03,6'h04,6'h15,6'h16,6'h17,6'h27,6'h28,6'h29,6'h31,6'h38};
    endcase
    return unpack_hand(v, 14);
  endfunction

  task automatic gen_hand(input int melds, output tq_t h);
    int kind, x, k, j;
    bit dup;
    int used [$];
    logic [5:0] tmp;
    logic [5:0] ill [8];
    ill = '{6'h00, 6'h0A, 6'h0F, 6'h1A, 6'h2C, 6'h38, 6'h30, 6'h3F};
    h = {};
    kind = int'($urandom_range(0, 9));
    if (melds == 4 && kind == 0) begin
      while (used.size() < 7) begin
        x = int'($urandom_range(0, 33));
        dup = 0;
        foreach (used[u]) if (used[u] == x) dup = 1;
        if (!dup) used.push_back(x);
      end
      foreach (used[u]) begin
        h.push_back(code_of(used[u]));
        h.push_back(code_of(used[u]));
      end
    end else begin
      for (int m = 0; m < melds; m++) begin
        if ($urandom_range(0, 1) == 0) begin
          x = int'($urandom_range(0, 33));
          repeat (3) h.push_back(code_of(x));
        end else begin
          x = int'($urandom_range(0, 2)) * 9 + int'($urandom_range(0, 6));
          for (int d = 0; d < 3; d++) h.push_back(code_of(x + d));
        end
      end
      x = int'($urandom_range(0, 33));
      h.push_back(code_of(x));
      h.push_back(code_of(x));
    end
    if (kind >= 1 && kind <= 3) h[$urandom_range(0, h.size() - 1)] = code_of(int'($urandom_range(0, 33)));
    if (kind == 4) h[$urandom_range(0, h.size() - 1)] = ill[$urandom_range(0, 7)];
    for (j = h.size() - 1; j > 0; j--) begin
      k = int'($urandom_range(0, j));
      tmp = h[j]; h[j] = h[k]; h[k] = tmp;
    end
  endtask

  // Drive one hand; expv < 0 takes the verdict from the reference model
  task automatic send_hand(input tq_t h, input int gap_pct, input int expv, input bit push);
    int n, guard;
    exp_t e;
    n = 0; guard = 0;
    while (n < h.size() && guard < 600) begin
      @(negedge clk);
      guard++;
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) drv_valid = 1'b0;
      else begin
        drv_valid = 1'b1;
        drv_tile  = h[n];
      end
      if (drv_valid && cur_ready) begin
        if (n == 0) first_acc = cyc + 1;
        n++;
        if (n == h.size()) begin
          last_acc = cyc + 1;
          if (push) begin
            e.v = (expv < 0) ? model(h, sel ? 1 : 4) : expv;
            e.t = last_acc;
            if (sel) exp1.push_back(e);
            else     exp4.push_back(e);
          end
        end
      end
    end
    if (n < h.size()) begin
      total++; nbad++;
      $display("FAIL send_hand: accepted %0d of %0d tiles before timeout", n, h.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  // Scoreboard monitors: pop the oldest expectation at every verdict pulse
  always @(negedge clk) begin
    if (!rst && bus4.out_valid) begin
      if (exp4.size() == 0) begin
        total++; nbad++;
        $display("FAIL dut4_unexpected_out: got out_valid=1 expected no pending hand");
      end else begin
        e4 = exp4.pop_front();
        chk("dut4_verdict", int'(bus4.out_data), e4.v);
        chk("dut4_latency", cyc - e4.t, 36);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.out_valid) begin
      if (exp1.size() == 0) begin
        total++; nbad++;
        $display("FAIL dut1_unexpected_out: got out_valid=1 expected no pending hand");
      end else begin
        e1 = exp1.pop_front();
        chk("dut1_verdict", int'(bus1.out_data), e1.v);
        chk("dut1_latency", cyc - e1.t, 36);
      end
    end
  end

  initial begin
    tq_t h;
    tq_t h7;
    int  dir_v [7];
    dir_v = '{1, 1, 0, EXP_7P, 2, 2, 2};
    rst = 1'b1; drv_valid = 1'b0; drv_tile = 6'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready4", int'(bus4.in_ready), 1);
    chk("reset_outv4", int'(bus4.out_valid), 0);
    chk("reset_data4", int'(bus4.out_data), 0);
    chk("reset_ready1", int'(bus1.in_ready), 1);
    chk("reset_outv1", int'(bus1.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready4", int'(bus4.in_ready), 1);

    // Directed hands, each first tile presented while the previous is busy
    for (int d = 0; d < 7; d++) begin
      send_hand(dir_hand(d), 0, dir_v[d], 1'b1);
      if (d > 0) chk("back_to_back_accept4", first_acc - prev_last, 37);
      prev_last = last_acc;
    end

    // Keep valid high while the judge is busy: nothing may be absorbed
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      drv_valid = (k < 35);
      drv_tile  = 6'h01;
      chk("busy_ready_low", int'(bus4.in_ready), 0);
    end

    // Abort a hand after seven tiles, then send a complete one
    h = dir_hand(0);
    h7 = h[0:6];
    send_hand(h7, 0, 0, 1'b0);
    @(negedge clk);
    drv_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(bus4.in_ready), 1);
    chk("abort_outv", int'(bus4.out_valid), 0);
    rst = 1'b0;
    send_hand(dir_hand(0), 0, 1, 1'b1);

    for (int r = 0; r < 40; r++) begin
      gen_hand(4, h);
      send_hand(h, 25, -1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 40)));
    end
    idle(45);

    // MELDS=1 instance
    sel = 1'b1;
    send_hand(unpack_hand({54'd0, 6'h12, 6'h13, 6'h14, 6'h34, 6'h34}, 5), 0, 1, 1'b1);
    prev_last = last_acc;
    send_hand(unpack_hand({54'd0, 6'h12, 6'h13, 6'h14, 6'h34, 6'h34}, 5), 0, 1, 1'b1);
    chk("back_to_back_accept1", first_acc - prev_last, 37);
    send_hand(unpack_hand({54'd0, 6'h12, 6'h13, 6'h14, 6'h34, 6'h31}, 5), 0, 0, 1'b1);
    for (int r = 0; r < 20; r++) begin
      gen_hand(1, h);
      send_hand(h, 25, -1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 40)));
    end
    idle(1);

    for (int k = 0; k < 200 && (exp4.size() != 0 || exp1.size() != 0); k++) @(negedge clk);
    if (exp4.size() != 0 || exp1.size() != 0) begin
      total++; nbad++;
      $display("FAIL drain: pending dut4=%0d dut1=%0d expected 0", exp4.size(), exp1.size());
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
`default_nettype wire
